// File: rtl/div_result_fixup_pkg.sv
// Shared constants for the divider result fix-up stage: flag-bit layout and
// the fill value used for the quotient on divide-by-zero.
package div_result_fixup_pkg;

  localparam int FLAG_DIV0 = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_QNEG = 2;
  localparam int FLAG_RNEG = 3;
  localparam int FLAG_W    = 4;

  localparam logic DIV0_QUO_ALL_ONES = 1'b1;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/div_result_fixup_if.sv
// Input (raw array result + operands) and output (final result) channels of
// the divider fix-up stage, each with a valid/ready handshake.
interface div_result_fixup_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_quo_raw;
  logic [N:0]   in_rem_raw;
  logic [N-1:0] in_dividend;
  logic [N-1:0] in_divisor;
  logic         in_signed;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_quo;
  logic [N-1:0] out_rem;
  logic         out_div0;
  logic         out_ovf;

  modport master (
    output in_valid, in_quo_raw, in_rem_raw, in_dividend, in_divisor, in_signed,
    output out_ready,
    input  in_ready,
    input  out_valid, out_quo, out_rem, out_div0, out_ovf
  );

  modport slave (
    input  in_valid, in_quo_raw, in_rem_raw, in_dividend, in_divisor, in_signed,
    input  out_ready,
    output in_ready,
    output out_valid, out_quo, out_rem, out_div0, out_ovf
  );
endinterface

// File: rtl/div_result_fixup_cond_negate.sv
// Conditional two's-complement negation; negating the most negative value
// wraps back to itself.
module div_result_fixup_cond_negate #(
  parameter int N = 16
) (
  input  logic signed [N-1:0] i_a,
  input  logic                i_neg,
  output logic signed [N-1:0] o_y
);
  assign o_y = i_neg ? -i_a : i_a;
endmodule

// File: rtl/div_result_fixup.sv
// Fix-up stage behind the non-restoring array divider: remainder correction,
// sign application and div0/overflow handling in a 2-stage valid/ready pipe.
module div_result_fixup
  import div_result_fixup_pkg::*;
#(
  parameter int N = 16
) (
  input logic               clk,
  input logic               rst_n,
  div_result_fixup_if.slave bus
);

  localparam logic [N-1:0] MIN_VAL  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  typedef struct packed {
    logic [N-1:0] quo;
    logic [N-1:0] rem;
    logic         div0;
    logic         ovf;
  } res_t;

  // Special cases override the signed array result; div0 wins over ovf.
  function automatic res_t apply_special(input flags_t f,
                                         input logic [N-1:0] quo_s,
                                         input logic [N-1:0] rem_s,
                                         input logic [N-1:0] dvd);
    res_t r;
    r.quo  = quo_s;
    r.rem  = rem_s;
    r.div0 = 1'b0;
    r.ovf  = 1'b0;
    if (f[FLAG_DIV0]) begin
      r.quo  = {N{DIV0_QUO_ALL_ONES}};
      r.rem  = dvd;
      r.div0 = 1'b1;
    end else if (f[FLAG_OVF]) begin
      r.quo  = MIN_VAL;
      r.rem  = '0;
      r.ovf  = 1'b1;
    end
    return r;
  endfunction

  logic               r_vld_p1;
  logic               r_vld_p2;
  logic [N-1:0]       r_quo_p1;
  logic [N-1:0]       r_rem_p1;
  logic [N-1:0]       r_dvd_p1;
  flags_t             r_flags_p1;
  res_t               r_res_p2;

  logic               w_adv_p2;
  logic               w_ld_p1;
  logic               w_dvs_neg_p0;
  logic signed [N-1:0] w_dvs_mag_p0;
  logic [N-1:0]       w_rem_c_p0;
  flags_t             w_flags_p0;
  logic signed [N-1:0] w_quo_s_p1;
  logic signed [N-1:0] w_rem_s_p1;

  // S2 can take new data when empty or draining this edge.
  assign w_adv_p2     = !r_vld_p2 || bus.out_ready;
  assign bus.in_ready = !r_vld_p1 || w_adv_p2;
  assign w_ld_p1      = bus.in_valid && bus.in_ready;

  // ---- stage 0 -> 1: divisor magnitude, remainder correction, flags ----
  assign w_dvs_neg_p0 = bus.in_signed & bus.in_divisor[N-1];

  div_result_fixup_cond_negate #(.N(N)) u_dvs_mag (
    .i_a   (bus.in_divisor),
    .i_neg (w_dvs_neg_p0),
    .o_y   (w_dvs_mag_p0)
  );

  assign w_rem_c_p0 = bus.in_rem_raw[N] ? (bus.in_rem_raw[N-1:0] + w_dvs_mag_p0)
                                        : bus.in_rem_raw[N-1:0];

  always_comb begin
    w_flags_p0            = '0;
    w_flags_p0[FLAG_DIV0] = (bus.in_divisor == '0);
    w_flags_p0[FLAG_OVF]  = bus.in_signed && (bus.in_dividend == MIN_VAL) &&
                            (bus.in_divisor == ALL_ONES);
    w_flags_p0[FLAG_QNEG] = bus.in_signed & (bus.in_dividend[N-1] ^ bus.in_divisor[N-1]);
    w_flags_p0[FLAG_RNEG] = bus.in_signed & bus.in_dividend[N-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_quo_p1   <= '0;
      r_rem_p1   <= '0;
      r_dvd_p1   <= '0;
      r_flags_p1 <= '0;
    end else if (bus.in_ready) begin
      r_vld_p1 <= bus.in_valid;
      if (w_ld_p1) begin
        r_quo_p1   <= bus.in_quo_raw;
        r_rem_p1   <= w_rem_c_p0;
        r_dvd_p1   <= bus.in_dividend;
        r_flags_p1 <= w_flags_p0;
      end
    end
  end

  // ---- stage 1 -> 2: sign application and special-case override ----
  div_result_fixup_cond_negate #(.N(N)) u_quo_sign (
    .i_a   (r_quo_p1),
    .i_neg (r_flags_p1[FLAG_QNEG]),
    .o_y   (w_quo_s_p1)
  );

  div_result_fixup_cond_negate #(.N(N)) u_rem_sign (
    .i_a   (r_rem_p1),
    .i_neg (r_flags_p1[FLAG_RNEG]),
    .o_y   (w_rem_s_p1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2 <= 1'b0;
      r_res_p2 <= '0;
    end else if (w_adv_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_res_p2 <= apply_special(r_flags_p1, w_quo_s_p1, w_rem_s_p1, r_dvd_p1);
      end
    end
  end

  assign bus.out_valid = r_vld_p2;
  assign bus.out_quo   = r_res_p2.quo;
  assign bus.out_rem   = r_res_p2.rem;
  assign bus.out_div0  = r_res_p2.div0;
  assign bus.out_ovf   = r_res_p2.ovf;

endmodule

// File: tb/tb_div_result_fixup.sv
// Directed-vector bench for div_result_fixup (N=8) with a queue scoreboard
// and an independent output monitor.
module tb_div_result_fixup;

  typedef struct packed {
    logic [7:0] quo;
    logic [7:0] rem;
    logic       div0;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;
  exp_t sb[$];

  logic       hold_prev = 1'b0;
  logic [17:0] held_out = '0;

  div_result_fixup_if #(.N(8)) bus ();

  div_result_fixup #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] q, input logic [8:0] r, input logic [7:0] dvd,
                      input logic [7:0] dvs, input logic sgn, input logic [7:0] eq,
                      input logic [7:0] er, input logic ed0, input logic eov);
    logic acc;
    exp_t e;
    bus.in_quo_raw  = q;
    bus.in_rem_raw  = r;
    bus.in_dividend = dvd;
    bus.in_divisor  = dvs;
    bus.in_signed   = sgn;
    bus.in_valid    = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (acc) begin
      e.quo = eq; e.rem = er; e.div0 = ed0; e.ovf = eov;
      sb.push_back(e);
    end else begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: in_ready never high for dvd=%h dvs=%h", dvd, dvs);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 100) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("drain_queue_size", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every negedge with valid&&ready means a transfer on the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && bus.out_valid)
        chk("stall_stable", 32'({bus.out_quo, bus.out_rem, bus.out_div0, bus.out_ovf}),
            32'(held_out));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'({bus.out_quo, bus.out_rem, bus.out_div0, bus.out_ovf}),
              32'h3ffff);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", 32'({bus.out_quo, bus.out_rem, bus.out_div0, bus.out_ovf}), 32'(e));
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      held_out  = {bus.out_quo, bus.out_rem, bus.out_div0, bus.out_ovf};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_quo_raw  = '0;
    bus.in_rem_raw  = '0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.in_signed   = 1'b0;
    bus.out_ready   = 1'b1;

    #12;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", 32'({bus.out_quo, bus.out_rem, bus.out_div0, bus.out_ovf}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Test 1: unsigned 100/7 plus latency check
    send(8'd14, 9'h002, 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0);
    @(negedge clk);
    chk("latency_not_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("latency_t2_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Tests 2-5 back to back
    send(8'd14, 9'h1FB, 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0);
    send(8'd14, 9'h002, 8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0);
    send(8'd14, 9'h002, 8'h64, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0, 1'b0);
    send(8'd14, 9'h1FB, 8'h9C, 8'hF9, 1'b1, 8'h0E, 8'hFE, 1'b0, 1'b0);
    send(8'h3C, 9'h1A5, 8'h55, 8'h00, 1'b0, 8'hFF, 8'h55, 1'b1, 1'b0);
    send(8'h3C, 9'h1A5, 8'h55, 8'h00, 1'b1, 8'hFF, 8'h55, 1'b1, 1'b0);
    send(8'h80, 9'h000, 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1);
    send(8'h00, 9'h080, 8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0);
    drain();

    // Test 6a: stall with 4 back-to-back inputs
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    fork
      begin
        send(8'd8,  9'h002, 8'd50,  8'd6,  1'b0, 8'd8,  8'd2,  1'b0, 1'b0);
        send(8'd22, 9'h002, 8'd200, 8'd9,  1'b0, 8'd22, 8'd2,  1'b0, 1'b0);
        send(8'd15, 9'h00F, 8'd255, 8'd16, 1'b0, 8'd15, 8'd15, 1'b0, 1'b0);
        send(8'd3,  9'h000, 8'd9,   8'd3,  1'b0, 8'd3,  8'd0,  1'b0, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        chk("stall_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("stall_accepted_two", 32'(sb.size()), 32'd2);
        @(negedge clk);
        chk("stall_in_ready_low2", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Test 6b: reset with both stages full
    bus.out_ready = 1'b0;
    send(8'd1, 9'h000, 8'd5, 8'd5, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0);
    send(8'd2, 9'h000, 8'd6, 8'd3, 1'b0, 8'd2, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_before_reset", 32'({bus.out_valid, bus.in_ready}), 32'b10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_drops_valid", 32'(bus.out_valid), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(8'd14, 9'h1FB, 8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_reset_not_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("post_reset_t2_valid", 32'(bus.out_valid), 32'd1);
    drain();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
